// File: rtl/pi_point_plotter.sv
// Monte Carlo pi plotter: clears the frame store, then plots pseudo-random points
// inside a SQUARE x SQUARE region, colouring them by quarter-circle membership.
// Inside/total counters give the estimate pi ~= 4 * insideCount / totalCount.
module pi_point_plotter #(
    parameter int unsigned FRAME_WIDTH  = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter int unsigned SQUARE       = 480,
    parameter int unsigned NUM_POINTS   = 10000,
    parameter logic [3:0]  BG_COLOR     = 4'h0,
    parameter logic [3:0]  IN_COLOR     = 4'hA,
    parameter logic [3:0]  OUT_COLOR    = 4'hC,
    parameter logic [15:0] SEED_X       = 16'hACE1,
    parameter logic [15:0] SEED_Y       = 16'h1D2B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [9:0]  writeX,
    output logic [9:0]  writeY,
    output logic [3:0]  wrColor,
    output logic        wrEnable,
    output logic [19:0] insideCount,
    output logic [19:0] totalCount
);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StPlot,
        StDone
    } state_e;

    localparam logic [9:0]  LastX     = 10'(FRAME_WIDTH - 1);
    localparam logic [9:0]  LastY     = 10'(FRAME_HEIGHT - 1);
    localparam logic [9:0]  SquareLim = 10'(SQUARE);
    localparam logic [9:0]  SquareTop = 10'(SQUARE - 1);
    localparam logic [20:0] RadiusSq  = 21'(SQUARE * SQUARE);
    localparam logic [19:0] LastPoint = 20'(NUM_POINTS - 1);

    state_e state_q, state_d;

    logic [15:0] lfsr_x_q, lfsr_x_d;
    logic [15:0] lfsr_y_q, lfsr_y_d;

    // Write-port registers; during CLEAR wr_x_q/wr_y_q double as the sweep position.
    logic [9:0]  wr_x_q, wr_x_d;
    logic [9:0]  wr_y_q, wr_y_d;
    logic [3:0]  wr_color_q, wr_color_d;
    logic        wr_en_q, wr_en_d;
    logic [19:0] inside_q, inside_d;
    logic [19:0] total_q, total_d;

    // Candidate point for the current PLOT cycle.
    logic [9:0]  pt_x, pt_y;
    logic [20:0] pt_x_w, pt_y_w;
    logic [20:0] dist_sq;
    logic        pt_accept;
    logic        pt_inside;

    // Point sampling and classification against the quarter circle.
    always_comb begin
        pt_x      = lfsr_x_q[9:0];
        pt_y      = lfsr_y_q[9:0];
        pt_x_w    = {11'b0, pt_x};
        pt_y_w    = {11'b0, pt_y};
        // Full 21-bit sum: each square fits in 20 bits since x, y <= 1023.
        dist_sq   = (pt_x_w * pt_x_w) + (pt_y_w * pt_y_w);
        pt_accept = (pt_x < SquareLim) && (pt_y < SquareLim);
        // A point exactly on the circle counts as outside.
        pt_inside = dist_sq < RadiusSq;
    end

    // Next-state, write-port and counter logic.
    always_comb begin
        state_d    = state_q;
        lfsr_x_d   = lfsr_x_q;
        lfsr_y_d   = lfsr_y_q;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_color_d = wr_color_q;
        wr_en_d    = 1'b0;
        inside_d   = inside_q;
        total_d    = total_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    // Load the first clear pixel so (0,0) is written on the first CLEAR cycle.
                    state_d    = StClear;
                    wr_en_d    = 1'b1;
                    wr_x_d     = 10'd0;
                    wr_y_d     = 10'd0;
                    wr_color_d = BG_COLOR;
                    inside_d   = 20'd0;
                    total_d    = 20'd0;
                end
            end

            StClear: begin
                wr_color_d = BG_COLOR;
                if (wr_x_q == LastX) begin
                    if (wr_y_q == LastY) begin
                        // Last pixel is on the bus now; the first PLOT cycle writes nothing.
                        state_d = StPlot;
                    end else begin
                        wr_en_d = 1'b1;
                        wr_x_d  = 10'd0;
                        wr_y_d  = wr_y_q + 10'd1;
                    end
                end else begin
                    wr_en_d = 1'b1;
                    wr_x_d  = wr_x_q + 10'd1;
                end
            end

            StPlot: begin
                // Fibonacci LFSR, taps 16,14,13,11, feedback into bit 0.
                lfsr_x_d = {lfsr_x_q[14:0],
                            lfsr_x_q[15] ^ lfsr_x_q[13] ^ lfsr_x_q[12] ^ lfsr_x_q[10]};
                lfsr_y_d = {lfsr_y_q[14:0],
                            lfsr_y_q[15] ^ lfsr_y_q[13] ^ lfsr_y_q[12] ^ lfsr_y_q[10]};
                if (pt_accept) begin
                    wr_en_d = 1'b1;
                    wr_x_d  = pt_x;
                    // Flip vertically so the plot origin sits bottom-left.
                    wr_y_d  = SquareTop - pt_y;
                    total_d = total_q + 20'd1;
                    if (pt_inside) begin
                        wr_color_d = IN_COLOR;
                        inside_d   = inside_q + 20'd1;
                    end else begin
                        wr_color_d = OUT_COLOR;
                    end
                    if (total_q == LastPoint) begin
                        state_d = StDone;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, LFSR, write-port and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            lfsr_x_q   <= SEED_X;
            lfsr_y_q   <= SEED_Y;
            wr_x_q     <= 10'd0;
            wr_y_q     <= 10'd0;
            wr_color_q <= 4'h0;
            wr_en_q    <= 1'b0;
            inside_q   <= 20'd0;
            total_q    <= 20'd0;
        end else begin
            state_q    <= state_d;
            lfsr_x_q   <= lfsr_x_d;
            lfsr_y_q   <= lfsr_y_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_color_q <= wr_color_d;
            wr_en_q    <= wr_en_d;
            inside_q   <= inside_d;
            total_q    <= total_d;
        end
    end

    // Status decode and output mapping.
    always_comb begin
        busy        = (state_q == StClear) || (state_q == StPlot);
        done        = (state_q == StDone);
        writeX      = wr_x_q;
        writeY      = wr_y_q;
        wrColor     = wr_color_q;
        wrEnable    = wr_en_q;
        insideCount = inside_q;
        totalCount  = total_q;
    end

endmodule

// File: tb/tb_pi_point_plotter.sv
// Directed bench for pi_point_plotter. The plot square is wide enough that the
// 10-bit LFSR window accepts points often, keeping runs short.
module tb_pi_point_plotter;

    localparam int unsigned W  = 3;
    localparam int unsigned H  = 700;
    localparam int unsigned SQ = 700;
    localparam int unsigned NP = 20;
    localparam logic [15:0] SX = 16'hACE1;
    localparam logic [15:0] SY = 16'h1D2B;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [9:0]  writeX;
    logic [9:0]  writeY;
    logic [3:0]  wrColor;
    logic        wrEnable;
    logic [19:0] insideCount;
    logic [19:0] totalCount;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lx;
    logic [15:0] m_ly;

    pi_point_plotter #(
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H),
        .SQUARE      (SQ),
        .NUM_POINTS  (NP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .writeX     (writeX),
        .writeY     (writeY),
        .wrColor    (wrColor),
        .wrEnable   (wrEnable),
        .insideCount(insideCount),
        .totalCount (totalCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Entered at the negedge of the first CLEAR cycle; leaves at the first PLOT cycle.
    task automatic clear_sweep(input string tag, input bit poke_start);
        int bad = 0;
        int first_bad = -1;
        int writes = 0;
        for (int i = 0; i < int'(W * H); i++) begin
            if (!(wrEnable === 1'b1 && writeX === 10'(i % W) && writeY === 10'(i / W) &&
                  wrColor === 4'h0 && busy === 1'b1 && done === 1'b0 &&
                  insideCount === 20'd0 && totalCount === 20'd0)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
            if (wrEnable === 1'b1) writes++;
            start = poke_start && (i == 100);
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_clear_bad_cycles"}, bad, 0);
        if (bad != 0) $display("  first bad clear index %0d", first_bad);
        check({tag, "_clear_writes"}, writes, W * H);
        check({tag, "_plot0_wr_en"}, wrEnable, 1'b0);
        check({tag, "_plot0_busy"}, busy, 1'b1);
    endtask

    // Entered at the negedge of the first PLOT cycle; leaves in the first DONE cycle.
    task automatic plot_run(input string tag, input bit poke_start,
                            output logic [9:0] fx, output logic [9:0] fy, output logic [3:0] fc,
                            output int ins_out);
        int pts = 0;
        int ins = 0;
        bit finished = 1'b0;
        logic [9:0] x, y;
        bit acc, inn;
        fx = '0; fy = '0; fc = '0;
        for (int c = 0; c < 4000 && !finished; c++) begin
            x   = m_lx[9:0];
            y   = m_ly[9:0];
            acc = (x < SQ) && (y < SQ);
            inn = (int'(x) * int'(x) + int'(y) * int'(y)) < int'(SQ * SQ);
            m_lx = lfsr_next(m_lx);
            m_ly = lfsr_next(m_ly);
            start = poke_start && (c == 5);
            @(negedge clk);
            start = 1'b0;
            check({tag, "_wr_en"}, wrEnable, acc);
            if (acc) begin
                pts++;
                if (inn) ins++;
                if (pts == 1) begin
                    fx = writeX; fy = writeY; fc = wrColor;
                end
                check({tag, "_x"}, writeX, x);
                check({tag, "_y"}, writeY, SQ - 1 - y);
                check({tag, "_color"}, wrColor, inn ? 4'hA : 4'hC);
                check({tag, "_total"}, totalCount, pts);
                check({tag, "_inside"}, insideCount, ins);
                if (pts == int'(NP)) finished = 1'b1;
            end
            check({tag, "_busy"}, busy, !finished);
            check({tag, "_done"}, done, finished);
        end
        check({tag, "_plot_finished"}, finished, 1'b1);
        ins_out = ins;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [9:0] fx, fy;
        logic [3:0] fc;
        int ins1, ins2, ins4;

        reset = 1'b1;
        start = 1'b0;
        m_lx  = SX;
        m_ly  = SY;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wr_en", wrEnable, 1'b0);
        check("rst_x", writeX, 10'd0);
        check("rst_y", writeY, 10'd0);
        check("rst_color", wrColor, 4'h0);
        check("rst_inside", insideCount, 20'd0);
        check("rst_total", totalCount, 20'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_wr_en", wrEnable, 1'b0);

        // Run 1: start ignored mid-CLEAR and mid-PLOT.
        pulse_start();
        check("r1_busy_after_start", busy, 1'b1);
        clear_sweep("r1", 1'b1);
        plot_run("r1", 1'b1, fx, fy, fc, ins1);
        // Seeds give x=0x0E1=225, y=0x12B=299: 225^2+299^2=140026 < 700^2, row 699-299.
        check("r1_first_x", fx, 10'd225);
        check("r1_first_y", fy, 10'd400);
        check("r1_first_color", fc, 4'hA);
        @(negedge clk);
        check("r1_done_wr_en", wrEnable, 1'b0);
        check("r1_done_hold", done, 1'b1);
        check("r1_total_frozen", totalCount, NP);
        check("r1_inside_frozen", insideCount, ins1);
        repeat (5) @(negedge clk);
        check("r1_total_still", totalCount, NP);
        check("r1_inside_still", insideCount, ins1);

        // Run 2: restart from DONE, LFSR sequence continues.
        pulse_start();
        check("r2_busy", busy, 1'b1);
        check("r2_done", done, 1'b0);
        check("r2_total_zero", totalCount, 20'd0);
        check("r2_inside_zero", insideCount, 20'd0);
        clear_sweep("r2", 1'b0);
        plot_run("r2", 1'b0, fx, fy, fc, ins2);
        @(negedge clk);

        // Run 3: abort with reset mid-PLOT.
        pulse_start();
        clear_sweep("r3", 1'b0);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_lx = SX;
        m_ly = SY;
        check("abort_wr_en", wrEnable, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_total", totalCount, 20'd0);
        check("abort_inside", insideCount, 20'd0);
        @(negedge clk);
        check("abort_idle_wr_en", wrEnable, 1'b0);

        // Run 4: reset reseeds the LFSRs, so the first point repeats run 1.
        pulse_start();
        clear_sweep("r4", 1'b0);
        plot_run("r4", 1'b0, fx, fy, fc, ins4);
        check("r4_first_x", fx, 10'd225);
        check("r4_first_y", fy, 10'd400);
        check("r4_first_color", fc, 4'hA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
